addsub_sequencer: RTL and testbench
===================================

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: p_Clock and p_Resetn.
REQ-002 p_Clock  input  1  rising-edge clock for all state.
REQ-003 p_Resetn  input  1  asynchronous active-low reset.
REQ-004 p_Run  input  1  instruction valid; accepted on a rising edge when p_Run=1 and p_Ready=1.
REQ-005 p_Instr  input  8  [7:6] opcode (00 MV, 01 MVI, 10 ADD, 11 SUB); [5:3] rx; [2:0] ry.
REQ-006 p_Imm  input  16  MVI immediate, sampled with the instruction.
REQ-007 p_Ready  output  1  high only in IDLE.
REQ-008 p_Done  output  1  one-cycle pulse in the write cycle of each instruction.
REQ-009 p_AddSub  output  1  arithmetic control: 1=add, 0=subtract.
REQ-010 p_RdAddr  input  3 / p_RdData  output  16  combinational register-file read port.
REQ-011 p_Zero, p_Neg, p_Ovf  output  1 each  result flags (see Configuration).

Function
REQ-012 SHALL hold an 8x16 register file R0..R7, plus a 16-bit operand register A and a 16-bit result register G.
REQ-013 FSM states: IDLE, T1, T2, T3; acceptance moves IDLE->T1 and latches opcode, rx, ry and p_Imm.
REQ-014 MV: in T1, R[rx] <= R[ry] at the end of T1; p_Done=1 in T1; next state IDLE.
REQ-015 MVI: in T1, R[rx] <= latched immediate; p_Done=1 in T1; next state IDLE.
REQ-016 ADD/SUB T1: A <= R[rx].
REQ-017 ADD/SUB T2: G <= A + R[ry] (ADD) or A - R[ry] (SUB); p_AddSub=1 for ADD, 0 for SUB.
REQ-018 ADD/SUB T3: R[rx] <= G; p_Done=1; next state IDLE.
REQ-019 Latency from the acceptance edge to the register update: 1 cycle for MV/MVI, 3 cycles for ADD/SUB.
REQ-020 Arithmetic is modulo 2^16: the carry/borrow out is discarded, so 0xFFFF+1=0x0000 and 0x0000-1=0xFFFF.
REQ-021 p_Run outside IDLE is ignored and the instruction is not queued.
REQ-022 When rx=ry, ADD doubles R[rx] and SUB zeroes R[rx].
REQ-023 p_RdData reflects the register contents before the write edge; the same-cycle write is not forwarded.
REQ-024 p_AddSub is 0 in every state except ADD-T2.
REQ-025 p_Ready may reassert in the cycle after p_Done, so back-to-back instructions are supported.

Reset
REQ-026 p_Resetn=0 SHALL immediately clear R0..R7, A, G, the latched instruction and the flags; FSM -> IDLE.
REQ-027 During reset: p_Ready=1 (state is IDLE) and p_Done=0, p_AddSub=0, p_Zero=p_Neg=p_Ovf=0.
REQ-028 Reset in T1..T3 SHALL abandon the instruction; no register write occurs.

Configuration
REQ-029 Macro ADDSUB_SEQUENCER_FLAGS_EN.
REQ-030 Macro defined: flags update at the end of ADD/SUB T2 and hold until the next ADD/SUB.
- p_Zero: G==0.
- p_Neg: G[15].
- p_Ovf: signed two's-complement overflow of the operation.
REQ-031 Macro undefined: p_Zero, p_Neg and p_Ovf are tied to 0 and no flag registers exist.

Structure
REQ-032 Shared package holds: opcode constants, state encodings, and the widths DATA_W=16, REG_AW=3.
REQ-033 Sub-module reg_bank8x16: one synchronous write port, two asynchronous read ports (operand and p_RdAddr).
REQ-034 The adder/subtractor is internal to addsub_sequencer and is steered by the same signal driven onto p_AddSub.

Verification
REQ-035 Reset mid-ADD: assert p_Resetn=0 in T2 -> R0..R7=0, p_Ready=1, no p_Done pulse.
REQ-036 Immediate load: MVI R1,0x0005 -> R1=0x0005 one cycle after acceptance, p_Done in T1.
REQ-037 Add/subtract sequence, starting from R1=0x0005, R2=0x0003:
- ADD R1,R2 -> R1=0x0008 at the end of T3; p_AddSub=1 in T2.
- Then SUB R1,R2 -> R1=0x0005; p_AddSub=0 in T2.
REQ-038 Wrap-around: R3=0xFFFF, R4=0x0001.
- ADD R3,R4 -> R3=0x0000, p_Zero=1 with the macro.
- SUB on R4=0x0000 by R5=0x0001 -> R4=0xFFFF, p_Neg=1 with the macro.
REQ-039 Overflow: R6=0x7FFF, ADD with R7=0x0001 -> R6=0x8000.
- With the macro: p_Ovf=1.
- Without the macro: p_Ovf=0.
REQ-040 Busy rejection: hold p_Run=1 throughout an ADD with a different instruction on p_Instr after acceptance -> only the first executes; the next is accepted in the cycle after p_Done.

Source files
------------

// File: rtl/addsub_sequencer_pkg.sv
// Shared types and widths for the add/subtract register sequencer.
package addsub_sequencer_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic [1:0] {
    OP_MV  = 2'b00,
    OP_MVI = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_e;

  typedef struct packed {
    opcode_e             op;
    logic [REG_AW-1:0]   rx;
    logic [REG_AW-1:0]   ry;
    logic [DATA_W-1:0]   imm;
  } instr_t;

  // Signed overflow of a + b_eff, where b_eff is already inverted for subtract.
  function automatic logic sum_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/reg_bank8x16.sv
// 8x16 register file: one synchronous write port, two asynchronous read ports.
module reg_bank8x16
  import addsub_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) regs_q <= '0;
    else if (we_i) regs_q[waddr_i] <= wdata_i;
  end

  // Reads see the pre-write contents; no write-through bypass.
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/addsub_sequencer.sv
// Multi-cycle MV/MVI/ADD/SUB sequencer over an 8x16 register file.
// Optional result flags enabled by defining ADDSUB_SEQUENCER_FLAGS_EN.
module addsub_sequencer
  import addsub_sequencer_pkg::*;
(
  input  logic        p_Clock,
  input  logic        p_Resetn,
  input  logic        p_Run,
  input  logic [7:0]  p_Instr,
  input  logic [15:0] p_Imm,
  output logic        p_Ready,
  output logic        p_Done,
  output logic        p_AddSub,
  input  logic [2:0]  p_RdAddr,
  output logic [15:0] p_RdData,
  output logic        p_Zero,
  output logic        p_Neg,
  output logic        p_Ovf
);

  state_e            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [REG_AW-1:0] opnd_addr;
  logic [DATA_W-1:0] opnd_data;
  logic              done;
  logic              addsub;

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] alu_res;

  reg_bank8x16 u_rf (
    .clk_i     (p_Clock),
    .rst_n_i   (p_Resetn),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (opnd_addr),
    .rdata_a_o (opnd_data),
    .raddr_b_i (p_RdAddr),
    .rdata_b_o (p_RdData)
  );

  // Single adder; subtract is a + ~b + 1, steered by the p_AddSub signal.
  assign b_eff   = addsub ? opnd_data : ~opnd_data;
  assign alu_res = a_q + b_eff + DATA_W'(!addsub);

  always_ff @(posedge p_Clock or negedge p_Resetn) begin
    if (!p_Resetn) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      a_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      g_q     <= g_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    a_d       = a_q;
    g_d       = g_q;
    rf_we     = 1'b0;
    rf_waddr  = instr_q.rx;
    rf_wdata  = g_q;
    opnd_addr = instr_q.ry;
    done      = 1'b0;
    addsub    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p_Run) begin
          instr_d.op  = opcode_e'(p_Instr[7:6]);
          instr_d.rx  = p_Instr[5:3];
          instr_d.ry  = p_Instr[2:0];
          instr_d.imm = p_Imm;
          state_d     = ST_T1;
        end
      end
      ST_T1: begin
        case (instr_q.op)
          OP_MV: begin
            rf_we    = 1'b1;
            rf_wdata = opnd_data;
            done     = 1'b1;
            state_d  = ST_IDLE;
          end
          OP_MVI: begin
            rf_we    = 1'b1;
            rf_wdata = instr_q.imm;
            done     = 1'b1;
            state_d  = ST_IDLE;
          end
          default: begin
            opnd_addr = instr_q.rx;
            a_d       = opnd_data;
            state_d   = ST_T2;
          end
        endcase
      end
      ST_T2: begin
        addsub  = (instr_q.op == OP_ADD);
        g_d     = alu_res;
        state_d = ST_T3;
      end
      ST_T3: begin
        rf_we    = 1'b1;
        rf_wdata = g_q;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign p_Ready  = (state_q == ST_IDLE);
  assign p_Done   = done;
  assign p_AddSub = addsub;

`ifdef ADDSUB_SEQUENCER_FLAGS_EN
  logic zero_q, neg_q, ovf_q;

  // Flags capture alongside G and hold through MV/MVI.
  always_ff @(posedge p_Clock or negedge p_Resetn) begin
    if (!p_Resetn) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == ST_T2) begin
      zero_q <= (alu_res == '0);
      neg_q  <= alu_res[DATA_W-1];
      ovf_q  <= sum_ovf(a_q[DATA_W-1], b_eff[DATA_W-1], alu_res[DATA_W-1]);
    end
  end

  assign p_Zero = zero_q;
  assign p_Neg  = neg_q;
  assign p_Ovf  = ovf_q;
`else
  assign p_Zero = 1'b0;
  assign p_Neg  = 1'b0;
  assign p_Ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed scoreboard bench for addsub_sequencer (flags checked when ADDSUB_SEQUENCER_FLAGS_EN is defined).
module tb_addsub_sequencer;

  localparam logic [1:0] MV = 2'b00, MVI = 2'b01, ADD = 2'b10, SUB = 2'b11;

  logic        p_Clock = 1'b0;
  logic        p_Resetn, p_Run;
  logic [7:0]  p_Instr;
  logic [15:0] p_Imm;
  logic        p_Ready, p_Done, p_AddSub;
  logic [2:0]  p_RdAddr;
  logic [15:0] p_RdData;
  logic        p_Zero, p_Neg, p_Ovf;

  addsub_sequencer dut (
    .p_Clock  (p_Clock),
    .p_Resetn (p_Resetn),
    .p_Run    (p_Run),
    .p_Instr  (p_Instr),
    .p_Imm    (p_Imm),
    .p_Ready  (p_Ready),
    .p_Done   (p_Done),
    .p_AddSub (p_AddSub),
    .p_RdAddr (p_RdAddr),
    .p_RdData (p_RdData),
    .p_Zero   (p_Zero),
    .p_Neg    (p_Neg),
    .p_Ovf    (p_Ovf)
  );

  always #5 p_Clock = ~p_Clock;

  typedef struct {
    logic [2:0]  rx;
    logic [15:0] val;
    logic        z, n, v;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl [8];
  logic        zf_m = 1'b0, nf_m = 1'b0, vf_m = 1'b0;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] rx,
                                 input logic [2:0] ry, input logic [15:0] imm);
    exp_t e;
    int   sa, sbv, sr;
    e.rx = rx; e.z = zf_m; e.n = nf_m; e.v = vf_m;
    case (op)
      MV:  e.val = mdl[ry];
      MVI: e.val = imm;
      default: begin
        sa  = int'($signed(mdl[rx]));
        sbv = int'($signed(mdl[ry]));
        sr  = (op == ADD) ? sa + sbv : sa - sbv;
        e.val = sr[15:0];
`ifdef ADDSUB_SEQUENCER_FLAGS_EN
        e.z = (e.val == 16'h0000);
        e.n = e.val[15];
        e.v = (sr > 32767) || (sr < -32768);
`endif
      end
    endcase
    return e;
  endfunction

  // Called just after the write edge: retire one scoreboard entry and compare.
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    mdl[e.rx] = e.val;
    zf_m = e.z; nf_m = e.n; vf_m = e.v;
    p_RdAddr = e.rx;
    #1;
    chk({tag, "_reg"},   32'(p_RdData), 32'(e.val));
    chk({tag, "_ready"}, 32'(p_Ready),  32'd1);
    chk({tag, "_zero"},  32'(p_Zero),   32'(e.z));
    chk({tag, "_neg"},   32'(p_Neg),    32'(e.n));
    chk({tag, "_ovf"},   32'(p_Ovf),    32'(e.v));
  endtask

  task automatic run_instr(input string tag, input logic [1:0] op, input logic [2:0] rx,
                           input logic [2:0] ry, input logic [15:0] imm);
    int   lat;
    logic found;
    @(negedge p_Clock);
    chk({tag, "_ready_in"}, 32'(p_Ready), 32'd1);
    sb.push_back(model(op, rx, ry, imm));
    p_Run = 1'b1; p_Instr = {op, rx, ry}; p_Imm = imm;
    @(posedge p_Clock);
    #1 p_Run = 1'b0; p_Instr = '0; p_Imm = '0;
    lat = 0; found = 1'b0;
    while (!found && lat < 8) begin
      @(negedge p_Clock);
      lat++;
      chk({tag, "_addsub"}, 32'(p_AddSub), 32'((op == ADD) && (lat == 2)));
      found = p_Done;
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
    chk({tag, "_latency"}, 32'(lat), (op[1] ? 32'd3 : 32'd1));
    p_RdAddr = rx;
    #1 chk({tag, "_no_fwd"}, 32'(p_RdData), 32'(mdl[rx]));
    @(posedge p_Clock);
    #1 pop_check(tag);
  endtask

  initial begin
    exp_t e;
    int   cyc, n_done;

    p_Resetn = 1'b0; p_Run = 1'b0; p_Instr = '0; p_Imm = '0; p_RdAddr = '0;
    for (int r = 0; r < 8; r++) mdl[r] = '0;
    #2;
    chk("rst_ready",  32'(p_Ready),  32'd1);
    chk("rst_done",   32'(p_Done),   32'd0);
    chk("rst_addsub", 32'(p_AddSub), 32'd0);
    chk("rst_flags",  32'({p_Zero, p_Neg, p_Ovf}), 32'd0);
    for (int r = 0; r < 8; r++) begin
      p_RdAddr = 3'(r);
      #1 chk("rst_reg", 32'(p_RdData), 32'd0);
    end
    @(negedge p_Clock) p_Resetn = 1'b1;

    run_instr("mvi_r1", MVI, 3'd1, 3'd0, 16'h0005);
    run_instr("mvi_r2", MVI, 3'd2, 3'd0, 16'h0003);
    run_instr("add_r1", ADD, 3'd1, 3'd2, 16'h0000);
    run_instr("sub_r1", SUB, 3'd1, 3'd2, 16'h0000);

    run_instr("mvi_r3", MVI, 3'd3, 3'd0, 16'hFFFF);
    run_instr("mvi_r4", MVI, 3'd4, 3'd0, 16'h0001);
    run_instr("wrap_add", ADD, 3'd3, 3'd4, 16'h0000);
    run_instr("mvi_r4z", MVI, 3'd4, 3'd0, 16'h0000);
    run_instr("mvi_r5", MVI, 3'd5, 3'd0, 16'h0001);
    run_instr("wrap_sub", SUB, 3'd4, 3'd5, 16'h0000);

    run_instr("mvi_r6", MVI, 3'd6, 3'd0, 16'h7FFF);
    run_instr("mvi_r7", MVI, 3'd7, 3'd0, 16'h0001);
    run_instr("ovf_add", ADD, 3'd6, 3'd7, 16'h0000);
    run_instr("mv_r0", MV, 3'd0, 3'd6, 16'h0000);
    run_instr("dbl_r2", ADD, 3'd2, 3'd2, 16'h0000);
    run_instr("clr_r1", SUB, 3'd1, 3'd1, 16'h0000);
    run_instr("ovf_sub", SUB, 3'd0, 3'd7, 16'h0000);

    // p_Run held high with a different instruction after acceptance.
    @(negedge p_Clock);
    sb.push_back(model(ADD, 3'd5, 3'd5, 16'h0000));
    p_Run = 1'b1; p_Instr = {ADD, 3'd5, 3'd5};
    @(posedge p_Clock);
    #1 p_Instr = {MVI, 3'd3, 3'd0}; p_Imm = 16'h1234;
    cyc = 0; n_done = 0;
    while (n_done == 0 && cyc < 8) begin
      @(negedge p_Clock);
      cyc++;
      chk("busy_ready_low", 32'(p_Ready), 32'd0);
      n_done += int'(p_Done);
    end
    chk("busy_latency", 32'(cyc), 32'd3);
    @(posedge p_Clock);
    #1 pop_check("busy_add");
    p_RdAddr = 3'd3;
    #1 chk("busy_not_queued", 32'(p_RdData), 32'(mdl[3]));
    @(negedge p_Clock);
    chk("busy_reaccept_ready", 32'(p_Ready), 32'd1);
    sb.push_back(model(MVI, 3'd3, 3'd0, 16'h1234));
    @(posedge p_Clock);
    #1 p_Run = 1'b0; p_Instr = '0; p_Imm = '0;
    @(negedge p_Clock);
    chk("busy_mvi_done", 32'(p_Done), 32'd1);
    @(posedge p_Clock);
    #1 pop_check("busy_mvi");

    // Reset asserted in T2 of an ADD.
    @(negedge p_Clock);
    p_Run = 1'b1; p_Instr = {ADD, 3'd2, 3'd2};
    @(posedge p_Clock);
    #1 p_Run = 1'b0; p_Instr = '0;
    @(negedge p_Clock);
    @(negedge p_Clock);
    chk("mid_t2_addsub", 32'(p_AddSub), 32'd1);
    p_Resetn = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(p_Ready), 32'd1);
    chk("mid_rst_done",  32'(p_Done),  32'd0);
    chk("mid_rst_flags", 32'({p_Zero, p_Neg, p_Ovf}), 32'd0);
    for (int r = 0; r < 8; r++) begin
      p_RdAddr = 3'(r);
      #1 chk("mid_rst_reg", 32'(p_RdData), 32'd0);
      mdl[r] = '0;
    end
    zf_m = 1'b0; nf_m = 1'b0; vf_m = 1'b0;
    @(negedge p_Clock) p_Resetn = 1'b1;
    repeat (3) begin
      @(negedge p_Clock);
      chk("mid_rst_no_done", 32'(p_Done), 32'd0);
    end
    p_RdAddr = 3'd2;
    #1 chk("mid_rst_r2_clear", 32'(p_RdData), 32'd0);

    run_instr("post_mvi", MVI, 3'd2, 3'd0, 16'h8001);
    run_instr("post_add", ADD, 3'd2, 3'd2, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
